// File: rtl/wb_arbiter_rr_nx1_if.sv
// rtl/wb_arbiter_rr_nx1_if.sv - bus bundle between N Wishbone requesters, the arbiter and the shared slave port
// slave modport is the arbiter's view; master modport is the surrounding masters and shared slave.
interface wb_arbiter_rr_nx1_if #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int N_MASTERS     = 4
);
  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int SW = WB_DATA_WIDTH / 8;
  localparam int N  = N_MASTERS;

  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat_w;
  logic [N*SW-1:0] m_sel;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [N-1:0]    m_cyc;
  logic [N-1:0]    m_stb;
  logic [N-1:0]    m_we;
  logic [DW-1:0]   m_dat_r;
  logic [N-1:0]    m_ack;
  logic [N-1:0]    m_err;

  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w;
  logic [SW-1:0]   s_sel;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic            s_cyc;
  logic            s_stb;
  logic            s_we;
  logic [DW-1:0]   s_dat_r;
  logic            s_ack;
  logic            s_err;

  modport slave (
    input  m_adr, m_dat_w, m_sel, m_cti, m_bte, m_cyc, m_stb, m_we,
    output m_dat_r, m_ack, m_err,
    output s_adr, s_dat_w, s_sel, s_cti, s_bte, s_cyc, s_stb, s_we,
    input  s_dat_r, s_ack, s_err
  );

  modport master (
    output m_adr, m_dat_w, m_sel, m_cti, m_bte, m_cyc, m_stb, m_we,
    input  m_dat_r, m_ack, m_err,
    input  s_adr, s_dat_w, s_sel, s_cti, s_bte, s_cyc, s_stb, s_we,
    output s_dat_r, s_ack, s_err
  );
endinterface

// File: rtl/wb_arbiter_rr_nx1.sv
// rtl/wb_arbiter_rr_nx1.sv - round-robin N:1 Wishbone arbiter with slave watchdog
// Grants whole CYC-to-CYC bus cycles; a dead IDLE cycle separates consecutive owners.
module wb_arbiter_rr_nx1 #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_MASTERS      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  wb_arbiter_rr_nx1_if.slave    bus,
  output logic [N_MASTERS-1:0]  gnt
);
  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int SW = WB_DATA_WIDTH / 8;
  localparam int N  = N_MASTERS;
  localparam int IW = $clog2(N);
  localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] last;
  logic [IW-1:0] gidx;
  logic [IW-1:0] winner;
  logic [IW-1:0] cand;
  logic          found;
  logic [WW-1:0] wdog;
  logic          busy;
  logic          g_cyc;
  logic          g_stb;
  logic          stall;
  logic          timeout;

  // Scan starts just after the previous owner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = last;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!found && bus.m_cyc[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign busy  = (state == ST_BUSY);
  assign g_cyc = bus.m_cyc[gidx];
  assign g_stb = bus.m_stb[gidx];

  assign bus.s_adr   = busy ? bus.m_adr[int'(gidx)*AW +: AW]   : '0;
  assign bus.s_dat_w = busy ? bus.m_dat_w[int'(gidx)*DW +: DW] : '0;
  assign bus.s_sel   = busy ? bus.m_sel[int'(gidx)*SW +: SW]   : '0;
  assign bus.s_cti   = busy ? bus.m_cti[int'(gidx)*3 +: 3]     : 3'b000;
  assign bus.s_bte   = busy ? bus.m_bte[int'(gidx)*2 +: 2]     : 2'b00;
  assign bus.s_cyc   = busy & g_cyc;
  assign bus.s_stb   = busy & g_stb;
  assign bus.s_we    = busy & bus.m_we[gidx];

  assign bus.m_dat_r = bus.s_dat_r;
  assign bus.m_ack   = busy ? (gnt & {N{bus.s_ack}}) : '0;
  assign bus.m_err   = busy ? (gnt & {N{bus.s_err}}) :
                       (state == ST_ERR) ? gnt : '0;

  // A slave answer in the limit cycle beats the watchdog because stall is then low.
  assign stall   = busy && g_stb && !bus.s_ack && !bus.s_err;
  assign timeout = (TIMEOUT_CYCLES != 0) && stall && (wdog == WW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      gnt   <= '0;
      last  <= IW'(N - 1);
      gidx  <= '0;
      wdog  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wdog <= '0;
          if (found) begin
            gnt   <= {{(N-1){1'b0}}, 1'b1} << winner;
            last  <= winner;
            gidx  <= winner;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!g_cyc) begin
            state <= ST_IDLE;
            gnt   <= '0;
            wdog  <= '0;
          end else if (timeout) begin
            state <= ST_ERR;
            wdog  <= '0;
          end else if (stall) begin
            if (wdog != '1) wdog <= wdog + 1'b1;
          end else begin
            wdog <= '0;
          end
        end
        ST_ERR: begin
          wdog  <= '0;
          state <= ST_REL;
        end
        ST_REL: begin
          wdog <= '0;
          if (!g_cyc) begin
            state <= ST_IDLE;
            gnt   <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          wdog  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_arbiter_rr_nx1.sv
// tb/tb_wb_arbiter_rr_nx1.sv - directed self-checking bench for wb_arbiter_rr_nx1
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
module tb_wb_arbiter_rr_nx1;
  logic       clk;
  logic       rstn;
  logic [3:0] gnt;
  int         total;
  int         bad;

  wb_arbiter_rr_nx1_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .N_MASTERS(4)) bus ();

  wb_arbiter_rr_nx1 #(
    .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .N_MASTERS(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle with m_cyc=req; slave acks in the first BUSY cycle,
  // the owner drops CYC for one cycle, then everyone requests again in the dead cycle.
  task automatic do_xfer(input string tag, input logic [3:0] exp_g, input logic [3:0] req);
    nxt();
    chk({tag, "_gnt"}, gnt, exp_g);
    bus.s_ack = 1'b1;
    #1 chk({tag, "_ack"}, bus.m_ack, exp_g);
    nxt();
    bus.s_ack = 1'b0;
    bus.m_cyc = req & ~exp_g;
    bus.m_stb = req & ~exp_g;
    #1 chk({tag, "_hold"}, gnt, exp_g);
    nxt();
    bus.m_cyc = req;
    bus.m_stb = req;
    #1 chk({tag, "_dead"}, gnt, 4'b0000);
  endtask

  task automatic pulse_reset();
    bus.m_cyc = '0;
    bus.m_stb = '0;
    rstn = 1'b0;
    nxt();
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    bus.m_adr = '0;  bus.m_dat_w = '0; bus.m_sel = '0; bus.m_cti = '0;
    bus.m_bte = '0;  bus.m_cyc = '0;   bus.m_stb = '0; bus.m_we = '0;
    bus.s_dat_r = '0; bus.s_ack = 1'b0; bus.s_err = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_scyc", bus.s_cyc, 1'b0);
    chk("rst_mack", bus.m_ack, 4'b0000);
    chk("rst_merr", bus.m_err, 4'b0000);
    rstn = 1'b1;

    // Single read by master 0, slave answers on the third BUSY cycle.
    nxt();
    bus.m_cyc = 4'b0001;
    bus.m_stb = 4'b0001;
    bus.m_adr[31:0] = 32'h100;
    bus.m_sel[3:0] = 4'hF;
    #1 chk("t1_pre_gnt", gnt, 4'b0000);
    nxt();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_sadr", bus.s_adr, 32'h100);
    chk("t1_scyc", bus.s_cyc, 1'b1);
    chk("t1_ssel", bus.s_sel, 4'hF);
    nxt();
    chk("t1_wait_ack", bus.m_ack, 4'b0000);
    nxt();
    bus.s_ack = 1'b1;
    bus.s_dat_r = 32'hCAFE;
    #1 chk("t1_ack", bus.m_ack, 4'b0001);
    chk("t1_dat", bus.m_dat_r, 32'hCAFE);
    nxt();
    bus.s_ack = 1'b0;
    bus.m_cyc = '0;
    bus.m_stb = '0;
    #1 chk("t1_ack_once", bus.m_ack, 4'b0000);
    chk("t1_scyc_drop", bus.s_cyc, 1'b0);
    nxt();
    chk("t1_idle", gnt, 4'b0000);

    // Two requesters alternate.
    pulse_reset();
    bus.m_cyc = 4'b0011;
    bus.m_stb = 4'b0011;
    do_xfer("t2_a", 4'b0001, 4'b0011);
    do_xfer("t2_b", 4'b0010, 4'b0011);
    do_xfer("t2_c", 4'b0001, 4'b0011);
    do_xfer("t2_d", 4'b0010, 4'b0011);

    // Four continuous requesters rotate through all owners.
    pulse_reset();
    bus.m_cyc = 4'b1111;
    bus.m_stb = 4'b1111;
    do_xfer("t3_a", 4'b0001, 4'b1111);
    do_xfer("t3_b", 4'b0010, 4'b1111);
    do_xfer("t3_c", 4'b0100, 4'b1111);
    do_xfer("t3_d", 4'b1000, 4'b1111);
    do_xfer("t3_e", 4'b0001, 4'b1111);

    // Silent slave: watchdog fires 9 cycles after STB rises.
    pulse_reset();
    bus.m_cyc = 4'b0100;
    bus.m_stb = 4'b0100;
    bus.m_adr[95:64] = 32'h200;
    nxt();
    chk("t4_gnt", gnt, 4'b0100);
    chk("t4_sadr", bus.s_adr, 32'h200);
    chk("t4_sstb", bus.s_stb, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      nxt();
      chk("t4_no_err", bus.m_err, 4'b0000);
      chk("t4_scyc_hold", bus.s_cyc, 1'b1);
    end
    nxt();
    chk("t4_err", bus.m_err, 4'b0100);
    chk("t4_err_scyc", bus.s_cyc, 1'b0);
    chk("t4_err_sstb", bus.s_stb, 1'b0);
    nxt();
    chk("t4_rel_err", bus.m_err, 4'b0000);
    chk("t4_rel_scyc", bus.s_cyc, 1'b0);
    chk("t4_rel_gnt", gnt, 4'b0100);
    nxt();
    chk("t4_rel_scyc2", bus.s_cyc, 1'b0);
    bus.m_cyc = '0;
    bus.m_stb = '0;
    nxt();
    chk("t4_idle", gnt, 4'b0000);

    // ACK arriving exactly at the watchdog limit wins.
    bus.m_cyc = 4'b1000;
    bus.m_stb = 4'b1000;
    nxt();
    chk("t5_gnt", gnt, 4'b1000);
    for (int k = 1; k <= 7; k++) begin
      nxt();
      chk("t5_wait_err", bus.m_err, 4'b0000);
    end
    nxt();
    bus.s_ack = 1'b1;
    #1 chk("t5_ack", bus.m_ack, 4'b1000);
    chk("t5_ack_no_err", bus.m_err, 4'b0000);
    nxt();
    bus.s_ack = 1'b0;
    bus.m_cyc = '0;
    bus.m_stb = '0;
    #1 chk("t5_after_err", bus.m_err, 4'b0000);
    chk("t5_after_gnt", gnt, 4'b1000);
    nxt();
    chk("t5_idle_gnt", gnt, 4'b0000);
    chk("t5_idle_err", bus.m_err, 4'b0000);

    // Reset in the middle of an incrementing burst.
    bus.m_cyc = 4'b0010;
    bus.m_stb = 4'b0010;
    bus.m_cti[5:3] = 3'b010;
    nxt();
    chk("t6_gnt", gnt, 4'b0010);
    chk("t6_scti", bus.s_cti, 3'b010);
    bus.s_ack = 1'b1;
    #1 chk("t6_ack", bus.m_ack, 4'b0010);
    rstn = 1'b0;
    nxt();
    chk("t6_rst_gnt", gnt, 4'b0000);
    chk("t6_rst_scyc", bus.s_cyc, 1'b0);
    chk("t6_rst_sstb", bus.s_stb, 1'b0);
    chk("t6_rst_mack", bus.m_ack, 4'b0000);
    rstn = 1'b1;
    bus.s_ack = 1'b0;
    bus.m_cyc = 4'b0011;
    bus.m_stb = 4'b0011;
    nxt();
    chk("t6_first_after_rst", gnt, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
